// File: rtl/tdm_demux.sv
// tdm_demux: slot-multiplexed link receiver.
// Assembles a frame in a shadow buffer, then publishes all lanes at once.
module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 1,
  parameter int IDX_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      frame_start,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_valid,
  output logic [IDX_W-1:0]          slot_idx,
  output logic                      synced,
  output logic                      frame_err
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(CHANNELS - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  typedef enum logic {HUNT, RECV} state_t;

  state_t                    state, state_nx;
  logic [IDX_W-1:0]          idx_nx;
  logic [IDX_W-1:0]          wr_idx;
  logic                      wr_en;
  logic                      pend, pend_nx;
  logic                      err_nx;
  logic [CHANNELS*WIDTH-1:0] shadow;

  // State, slot counter and pulse flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      slot_idx  <= '0;
      pend      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      slot_idx  <= idx_nx;
      pend      <= pend_nx;
      frame_err <= err_nx;
    end
  end

  // Next state, slot write target, publish and error decisions
  always_comb begin
    state_nx = state;
    idx_nx   = slot_idx;
    pend_nx  = 1'b0;
    err_nx   = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = slot_idx;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (frame_start) begin
            wr_en    = 1'b1;
            wr_idx   = '0;
            idx_nx   = ONE;
            state_nx = RECV;
          end
        end
        RECV: begin
          wr_en = 1'b1;
          if (frame_start) begin
            wr_idx = '0;
            idx_nx = ONE;
            err_nx = (slot_idx != '0);
          end else if (slot_idx == LAST) begin
            idx_nx  = '0;
            pend_nx = 1'b1;
          end else begin
            idx_nx = slot_idx + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Shadow buffer fills slot by slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      shadow <= '0;
    else if (wr_en)
      shadow[int'(wr_idx)*WIDTH +: WIDTH] <= in_data;
  end

  // Publish the completed frame one cycle after its last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= pend;
      if (pend)
        out_data <= shadow;
    end
  end

  assign synced = (state == RECV);

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: scoreboard bench for tdm_demux.
// Two instances (4x1 and 3x8) share one randomized stimulus stream.
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [7:0]  din = '0;

  logic [3:0]  od0;
  logic        ov0, sy0, fe0;
  logic [1:0]  si0;
  logic [23:0] od1;
  logic        ov1, sy1, fe1;
  logic [1:0]  si1;

  int checks = 0;
  int failures = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          m_sync[2];
  int          m_idx[2];
  int          m_err[2];
  logic [7:0]  m_sh[2][4];
  int          chn[2] = '{4, 3};
  int          wd[2]  = '{1, 8};
  int          seen_err[2] = '{0, 0};
  logic [31:0] cur0 = '0;
  logic [31:0] cur1 = '0;

  tdm_demux #(.CHANNELS(4), .WIDTH(1), .IDX_W(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_data(din[0:0]), .frame_start(frame_start),
    .out_data(od0), .out_valid(ov0), .slot_idx(si0),
    .synced(sy0), .frame_err(fe0)
  );

  tdm_demux #(.CHANNELS(3), .WIDTH(8), .IDX_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_data(din), .frame_start(frame_start),
    .out_data(od1), .out_valid(ov1), .slot_idx(si1),
    .synced(sy1), .frame_err(fe1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_sync[k] = 0;
      m_idx[k]  = 0;
      for (int i = 0; i < 4; i++) m_sh[k][i] = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_beat(input logic fs, input logic [7:0] d);
    for (int k = 0; k < 2; k++) begin
      logic [7:0]  w;
      logic [31:0] p;
      w = (k == 0) ? (d & 8'h01) : d;
      if (m_sync[k] == 0) begin
        if (fs) begin
          m_sync[k] = 1;
          m_sh[k][0] = w;
          m_idx[k] = 1;
        end
      end else if (fs) begin
        if (m_idx[k] != 0) m_err[k]++;
        m_sh[k][0] = w;
        m_idx[k] = 1;
      end else begin
        m_sh[k][m_idx[k]] = w;
        m_idx[k]++;
        if (m_idx[k] == chn[k]) begin
          m_idx[k] = 0;
          p = '0;
          for (int i = 0; i < chn[k]; i++)
            p = p + (32'(m_sh[k][i]) << (i * wd[k]));
          if (k == 0) q0.push_back(p);
          else q1.push_back(p);
        end
      end
    end
  endtask

  task automatic beat(input logic fs, input logic [7:0] d);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    frame_start = fs;
    din = d;
    model_beat(fs, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      frame_start = 1'b0;
      din = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    frame_start = 1'b0;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_out_data0", 32'(od0), 32'h0);
    chk("rst_out_data1", 32'(od1), 32'h0);
    chk("rst_out_valid", 32'({ov0, ov1}), 32'h0);
    chk("rst_synced", 32'({sy0, sy1}), 32'h0);
    chk("rst_slot_idx", 32'({si0, si1}), 32'h0);
    chk("rst_frame_err", 32'({fe0, fe1}), 32'h0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Monitor: pops expected frames on each publish and checks hold between
  always @(negedge clk) begin
    if (!rst_n) begin
      cur0 = '0;
      cur1 = '0;
    end else begin
      if (ov0) begin
        if (q0.size() == 0) chk("pub0_unexpected", 32'(od0), 32'hx);
        else begin
          cur0 = q0.pop_front();
          chk("pub0_data", 32'(od0), cur0);
        end
      end else chk("hold0", 32'(od0), cur0);
      if (ov1) begin
        if (q1.size() == 0) chk("pub1_unexpected", 32'(od1), 32'hx);
        else begin
          cur1 = q1.pop_front();
          chk("pub1_data", 32'(od1), cur1);
        end
      end else chk("hold1", 32'(od1), cur1);
      if (fe0) seen_err[0]++;
      if (fe1) seen_err[1]++;
    end
  end

  initial begin
    m_err = '{0, 0};
    model_clear();
    do_reset();

    // beats before any marker are dropped
    beat(1'b0, 8'h01);
    beat(1'b0, 8'h01);
    beat(1'b0, 8'h00);
    idle(2);
    chk("hunt_synced", 32'({sy0, sy1}), 32'h0);
    chk("hunt_slot", 32'(si0), 32'(m_idx[0]));

    // basic frame 1,0,1,1
    beat(1'b1, 8'h01);
    beat(1'b0, 8'h00);
    beat(1'b0, 8'h01);
    beat(1'b0, 8'h11);
    idle(1);
    chk("lat_no_early", 32'(ov0), 32'h0);
    idle(1);
    chk("lat_pulse", 32'(ov0), 32'h1);
    chk("frame_1101", 32'(od0), 32'hD);
    idle(1);
    chk("pulse_once", 32'(ov0), 32'h0);
    chk("synced_recv", 32'(sy0), 32'h1);

    // short frame
    do_reset();
    beat(1'b1, 8'h01);
    beat(1'b0, 8'h01);
    beat(1'b0, 8'h01);
    beat(1'b1, 8'h00);
    idle(1);
    chk("short_err", 32'(fe0), 32'h1);
    chk("short_slot", 32'(si0), 32'h1);
    chk("short_nopub", 32'({ov0, od0}), 32'h0);
    idle(1);
    chk("short_err_pulse", 32'(fe0), 32'h0);

    // reset mid-frame, then a clean frame
    idle(3);
    beat(1'b1, 8'h5A);
    beat(1'b0, 8'h01);
    idle(1);
    chk("mid_slot2", 32'(si0), 32'h2);
    do_reset();
    beat(1'b1, 8'h00);
    beat(1'b0, 8'h01);
    beat(1'b0, 8'h00);
    beat(1'b0, 8'h01);
    idle(3);
    chk("post_rst_frame", 32'(od0), 32'hA);

    // wide lanes
    do_reset();
    beat(1'b1, 8'hA5);
    beat(1'b0, 8'h3C);
    beat(1'b0, 8'hFF);
    idle(3);
    chk("wide_frame", 32'(od1), 32'hFF3CA5);

    // back-to-back frames, second unmarked, with gaps
    beat(1'b1, 8'($urandom));
    for (int i = 0; i < 11; i++) begin
      idle(i % 4);
      beat(1'b0, 8'($urandom));
    end
    idle(3);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      int g;
      g = $urandom_range(0, 5);
      if (g < 4 && g > 0) idle(g);
      beat(($urandom_range(0, 9) == 0), 8'($urandom));
    end
    idle(6);

    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);
    chk("err_count0", 32'(seen_err[0]), 32'(m_err[0]));
    chk("err_count1", 32'(seen_err[1]), 32'(m_err[1]));
    chk("end_slot0", 32'(si0), 32'(m_idx[0]));
    chk("end_slot1", 32'(si1), 32'(m_idx[1]));
    chk("end_synced", 32'({sy0, sy1}), 32'({m_sync[0] != 0, m_sync[1] != 0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
